// File: rtl/pol_pkg.sv
// Shared widths and defaults for the pooling-core / GLB read interface.
package pol_pkg;

  // Default configuration of the read-interface controller.
  localparam int DEF_NUM_PORT  = 6;
  localparam int DEF_IDX_WIDTH = 10;
  localparam int DEF_ACT_WIDTH = 8;
  localparam int DEF_COMP_CORE = 64;
  localparam int DEF_CMD_DEPTH = 4;
  localparam int DEF_OUT_DEPTH = 4;
  localparam int DEF_MAX_OUT   = 4;

  // Width of a port index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Derived widths for the default configuration.
  localparam int PW    = idx_w(DEF_NUM_PORT);
  localparam int TAG_W = cnt_w(DEF_MAX_OUT);
  localparam int OFM_W = DEF_ACT_WIDTH * DEF_COMP_CORE;

endpackage

// File: rtl/FIFO_FWFT.sv
// First-word-fall-through FIFO: the head entry is visible on dout_o while
// empty_o is low. Pushes while full and pops while empty are ignored, and
// clr_i wins over any push or pop in the same cycle. DEPTH is a power of 2.
module FIFO_FWFT #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers and occupancy; pointer wrap relies on the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr_i,
// searching upward and wrapping from N-1 back to 0.
module rr_arb #(
  parameter int N  = 6,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o
);

  logic [PW:0] cand;
  logic        found;

  // Walk the ports starting at the pointer; first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!found && req_i[cand[PW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[cand[PW-1:0]]    = 1'b1;
        gnt_idx_o              = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/pol_mic_rr.sv
// Read-interface controller between the pooling cores and the GLB.
// Requests are merged round-robin into a command FIFO, issued to the GLB
// with a bounded number of outstanding reads, and every returned word is
// tagged in request order with its requesting core before delivery.
module pol_mic_rr
  import pol_pkg::*;
#(
  parameter int NUM_PORT  = DEF_NUM_PORT,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH,
  parameter int ACT_WIDTH = DEF_ACT_WIDTH,
  parameter int COMP_CORE = DEF_COMP_CORE,
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  parameter int OUT_DEPTH = DEF_OUT_DEPTH,
  parameter int MAX_OUT   = DEF_MAX_OUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic [NUM_PORT-1:0]             POLMIC_AddrVld,
  input  logic [NUM_PORT*IDX_WIDTH-1:0]   POLMIC_Addr,
  output logic [NUM_PORT-1:0]             MICPOL_AddrRdy,
  output logic                            MICGLB_AddrVld,
  output logic [IDX_WIDTH-1:0]            MICGLB_Addr,
  input  logic                            GLBMIC_AddrRdy,
  input  logic [ACT_WIDTH*COMP_CORE-1:0]  GLBMIC_Ofm,
  input  logic                            GLBMIC_OfmVld,
  output logic                            MICGLB_OfmRdy,
  output logic [ACT_WIDTH*COMP_CORE-1:0]  MICPOL_Ofm,
  output logic [NUM_PORT-1:0]             MICPOL_OfmVld,
  input  logic [NUM_PORT-1:0]             POLMIC_OfmRdy,
  output logic                            MIC_Err
);

  localparam int PORT_W = idx_w(NUM_PORT);
  localparam int CNT_W  = cnt_w(MAX_OUT);
  localparam int WORD_W = ACT_WIDTH * COMP_CORE;

  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;

  logic [NUM_PORT-1:0] gnt;
  logic [PORT_W-1:0]   gnt_idx;
  logic                req_acc;

  logic [PORT_W+IDX_WIDTH-1:0] cmd_din, cmd_dout;
  logic                        cmd_full, cmd_empty;
  logic [PORT_W-1:0]           cmd_port;

  logic [PORT_W-1:0] tag_head;
  logic              tag_full, tag_empty, tag_pop;

  logic [PORT_W+WORD_W-1:0] out_dout;
  logic                     out_full, out_empty, out_pop;
  logic [PORT_W-1:0]        out_port;

  logic addr_hs, data_hs, stray;

  rr_arb #(.N(NUM_PORT), .PW(PORT_W)) u_arb (
    .req_i     (POLMIC_AddrVld),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Request side: a grant is only offered while the command FIFO has room.
  assign MICPOL_AddrRdy = gnt & {NUM_PORT{!cmd_full}};
  assign req_acc        = |MICPOL_AddrRdy;
  assign cmd_din        = {gnt_idx, POLMIC_Addr[gnt_idx*IDX_WIDTH +: IDX_WIDTH]};
  assign cmd_port       = cmd_dout[IDX_WIDTH +: PORT_W];

  FIFO_FWFT #(.WIDTH(PORT_W+IDX_WIDTH), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(clk), .rst_n(rst_n), .clr_i(clr),
    .push_i(req_acc), .din_i(cmd_din), .pop_i(addr_hs),
    .dout_o(cmd_dout), .full_o(cmd_full), .empty_o(cmd_empty)
  );

  // Issue side: the tag FIFO tracks inflight exactly, so its full flag is
  // simply a second guard on the outstanding-read bound.
  assign MICGLB_AddrVld = !cmd_empty && (inflight_q < CNT_W'(MAX_OUT)) && !tag_full;
  assign MICGLB_Addr    = cmd_dout[IDX_WIDTH-1:0];
  assign addr_hs        = MICGLB_AddrVld && GLBMIC_AddrRdy;

  FIFO_FWFT #(.WIDTH(PORT_W), .DEPTH(MAX_OUT)) u_tag (
    .clk(clk), .rst_n(rst_n), .clr_i(clr),
    .push_i(addr_hs), .din_i(cmd_port), .pop_i(tag_pop),
    .dout_o(tag_head), .full_o(tag_full), .empty_o(tag_empty)
  );

  // Return side: data with no outstanding read is dropped and flagged.
  assign MICGLB_OfmRdy = !out_full;
  assign data_hs       = GLBMIC_OfmVld && MICGLB_OfmRdy;
  assign tag_pop       = data_hs && (inflight_q != '0) && !tag_empty;
  assign stray         = data_hs && !tag_pop;

  FIFO_FWFT #(.WIDTH(PORT_W+WORD_W), .DEPTH(OUT_DEPTH)) u_out (
    .clk(clk), .rst_n(rst_n), .clr_i(clr),
    .push_i(tag_pop), .din_i({tag_head, GLBMIC_Ofm}), .pop_i(out_pop),
    .dout_o(out_dout), .full_o(out_full), .empty_o(out_empty)
  );

  // Delivery: shared data bus, one-hot valid steered by the head tag.
  assign out_port      = out_dout[WORD_W +: PORT_W];
  assign MICPOL_Ofm    = out_dout[WORD_W-1:0];
  assign MICPOL_OfmVld = out_empty ? '0 : (NUM_PORT'(1) << out_port);
  assign out_pop       = !out_empty && POLMIC_OfmRdy[out_port];
  assign MIC_Err       = err_q;

  // Next-state for pointer, outstanding count and sticky error; clr wins.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    err_d      = err_q | stray;
    if (req_acc) begin
      rr_ptr_d = (gnt_idx == PORT_W'(NUM_PORT-1)) ? '0 : gnt_idx + 1'b1;
    end
    if (addr_hs && !tag_pop)      inflight_d = inflight_q + 1'b1;
    else if (!addr_hs && tag_pop) inflight_d = inflight_q - 1'b1;
    if (clr) begin
      rr_ptr_d   = '0;
      inflight_d = '0;
      err_d      = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_pol_mic_rr.sv
// Bench for pol_mic_rr: hand-computed arbitration table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_pol_mic_rr;
  import pol_pkg::*;

  localparam int NP   = DEF_NUM_PORT;
  localparam int AWD  = DEF_IDX_WIDTH;
  localparam int WW   = OFM_W;
  localparam int CMDD = DEF_CMD_DEPTH;
  localparam int OUTD = DEF_OUT_DEPTH;
  localparam int MAXO = DEF_MAX_OUT;

  typedef logic [WW-1:0] w_t;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic [NP-1:0]     pol_addr_vld;
  logic [NP*AWD-1:0] pol_addr;
  logic [NP-1:0]     pol_addr_rdy;
  logic              glb_addr_vld;
  logic [AWD-1:0]    glb_addr;
  logic              glb_addr_rdy;
  w_t                glb_ofm;
  logic              glb_ofm_vld;
  logic              glb_ofm_rdy;
  w_t                pol_ofm;
  logic [NP-1:0]     pol_ofm_vld;
  logic [NP-1:0]     pol_ofm_rdy;
  logic              mic_err;

  pol_mic_rr dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .POLMIC_AddrVld(pol_addr_vld), .POLMIC_Addr(pol_addr),
    .MICPOL_AddrRdy(pol_addr_rdy),
    .MICGLB_AddrVld(glb_addr_vld), .MICGLB_Addr(glb_addr),
    .GLBMIC_AddrRdy(glb_addr_rdy),
    .GLBMIC_Ofm(glb_ofm), .GLBMIC_OfmVld(glb_ofm_vld),
    .MICGLB_OfmRdy(glb_ofm_rdy),
    .MICPOL_Ofm(pol_ofm), .MICPOL_OfmVld(pol_ofm_vld),
    .POLMIC_OfmRdy(pol_ofm_rdy),
    .MIC_Err(mic_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queues of commands, tags and delivered words.
  typedef struct { int port; logic [AWD-1:0] addr; } cmd_t;
  typedef struct { int port; w_t data; } out_t;
  cmd_t m_cmd[$];
  int   m_tag[$];
  out_t m_out[$];
  int   m_ptr, m_infl;
  logic m_err;
  bit   last_ahs, last_dhs;
  int   glb_n;

  typedef struct { logic [NP-1:0] req; logic [NP-1:0] rdy; logic av; } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic w_t rand_word();
    w_t w;
    for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_cmd.delete(); m_tag.delete(); m_out.delete();
    m_ptr = 0; m_infl = 0; m_err = 1'b0; glb_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; pol_addr_vld = '0; pol_addr = '0;
    glb_addr_rdy = 1'b0; glb_ofm = '0; glb_ofm_vld = 1'b0; pol_ofm_rdy = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic cyc();
    int gi;
    logic [NP-1:0] e_rdy, e_ov;
    logic e_av, e_or;
    bit acc, ahs, dhs, ohs;
    cmd_t c;
    out_t o;
    #1;
    gi = -1;
    for (int i = 0; i < NP; i++)
      if (gi < 0 && pol_addr_vld[(m_ptr + i) % NP]) gi = (m_ptr + i) % NP;
    e_rdy = '0;
    if (gi >= 0 && m_cmd.size() < CMDD) e_rdy[gi] = 1'b1;
    e_av = (m_cmd.size() > 0) && (m_infl < MAXO);
    e_or = m_out.size() < OUTD;
    e_ov = '0;
    if (m_out.size() > 0) e_ov[m_out[0].port] = 1'b1;
    chk("addr_rdy", w_t'(pol_addr_rdy), w_t'(e_rdy));
    chk("glb_addr_vld", w_t'(glb_addr_vld), w_t'(e_av));
    if (e_av) chk("glb_addr", w_t'(glb_addr), w_t'(m_cmd[0].addr));
    chk("glb_ofm_rdy", w_t'(glb_ofm_rdy), w_t'(e_or));
    chk("pol_ofm_vld", w_t'(pol_ofm_vld), w_t'(e_ov));
    if (m_out.size() > 0) chk("pol_ofm", pol_ofm, m_out[0].data);
    chk("mic_err", w_t'(mic_err), w_t'(m_err));
    acc = (e_rdy != '0);
    ahs = e_av && glb_addr_rdy;
    dhs = glb_ofm_vld && e_or;
    ohs = (m_out.size() > 0) && pol_ofm_rdy[m_out[0].port];
    last_ahs = ahs;
    last_dhs = dhs;
    if (clr) begin
      m_cmd.delete(); m_tag.delete(); m_out.delete();
      m_ptr = 0; m_infl = 0; m_err = 1'b0;
    end else begin
      if (ohs) begin
        o = m_out.pop_front();
        $display("deliver port %0d word[31:0]=%h", o.port, o.data[31:0]);
      end
      if (dhs) begin
        if (m_infl > 0) begin
          m_out.push_back('{m_tag.pop_front(), glb_ofm});
          m_infl--;
        end else begin
          m_err = 1'b1;
        end
      end
      if (ahs) begin
        c = m_cmd.pop_front();
        m_tag.push_back(c.port);
        m_infl++;
      end
      if (acc) begin
        m_cmd.push_back('{gi, pol_addr[gi*AWD +: AWD]});
        m_ptr = (gi + 1) % NP;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // GLB behaviour: returns one word per issued read, holding it until taken.
  task automatic glb_update(input int pct);
    if (glb_ofm_vld && last_dhs) begin
      glb_ofm_vld = 1'b0;
      glb_n--;
    end
    if (last_ahs) glb_n++;
    if (!glb_ofm_vld && glb_n > 0 && $urandom_range(0, 99) < pct) begin
      glb_ofm_vld = 1'b1;
      glb_ofm     = rand_word();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    w_t wa, wb;
    bit drained;
    tbl[0]  = '{6'b101010, 6'b000010, 1'b0};
    tbl[1]  = '{6'b101010, 6'b001000, 1'b1};
    tbl[2]  = '{6'b101010, 6'b100000, 1'b1};
    tbl[3]  = '{6'b101010, 6'b000010, 1'b1};
    tbl[4]  = '{6'b000000, 6'b000000, 1'b1};
    tbl[5]  = '{6'b000001, 6'b000001, 1'b0};
    tbl[6]  = '{6'b110001, 6'b010000, 1'b0};
    tbl[7]  = '{6'b110001, 6'b100000, 1'b0};
    tbl[8]  = '{6'b111111, 6'b000001, 1'b0};
    tbl[9]  = '{6'b111111, 6'b000000, 1'b0};
    tbl[10] = '{6'b000100, 6'b000000, 1'b0};

    do_reset();
    #1;
    chk("rst_addr_rdy", w_t'(pol_addr_rdy), w_t'(6'b0));
    chk("rst_glb_vld", w_t'(glb_addr_vld), w_t'(1'b0));
    chk("rst_ofm_rdy", w_t'(glb_ofm_rdy), w_t'(1'b1));
    chk("rst_ofm_vld", w_t'(pol_ofm_vld), w_t'(6'b0));
    chk("rst_err", w_t'(mic_err), w_t'(1'b0));

    // Arbitration table: GLB takes addresses but returns nothing.
    glb_addr_rdy = 1'b1;
    for (int k = 0; k < 11; k++) begin
      pol_addr_vld = tbl[k].req;
      for (int i = 0; i < NP; i++) pol_addr[i*AWD +: AWD] = AWD'(i*64 + k);
      #1;
      $display("vec %0d req=%b addr_rdy=%b glb_vld=%b", k, tbl[k].req, pol_addr_rdy, glb_addr_vld);
      chk("tbl_addr_rdy", w_t'(pol_addr_rdy), w_t'(tbl[k].rdy));
      chk("tbl_glb_vld", w_t'(glb_addr_vld), w_t'(tbl[k].av));
      cyc();
    end

    // Four reads outstanding: one return allows exactly one more issue.
    pol_addr_vld = '0;
    wa = rand_word();
    glb_ofm = wa; glb_ofm_vld = 1'b1;
    #1;
    chk("cap_glb_vld", w_t'(glb_addr_vld), w_t'(1'b0));
    cyc();
    glb_ofm_vld = 1'b0;
    #1;
    chk("ret_ofm_vld", w_t'(pol_ofm_vld), w_t'(6'b000010));
    chk("ret_ofm", pol_ofm, wa);
    chk("reissue_vld", w_t'(glb_addr_vld), w_t'(1'b1));
    chk("reissue_addr", w_t'(glb_addr), w_t'(10'd5));
    cyc();
    #1;
    chk("cap_again", w_t'(glb_addr_vld), w_t'(1'b0));
    wb = rand_word();
    glb_ofm = wb; glb_ofm_vld = 1'b1;
    cyc();
    glb_ofm_vld = 1'b0;

    // Clear with three reads outstanding, then a stray return.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    chk("clr_glb_vld", w_t'(glb_addr_vld), w_t'(1'b0));
    chk("clr_ofm_vld", w_t'(pol_ofm_vld), w_t'(6'b0));
    chk("clr_ofm_rdy", w_t'(glb_ofm_rdy), w_t'(1'b1));
    chk("clr_err", w_t'(mic_err), w_t'(1'b0));
    glb_addr_rdy = 1'b0;
    pol_addr_vld = 6'b100001;
    #1;
    chk("clr_rr_ptr", w_t'(pol_addr_rdy), w_t'(6'b000001));
    cyc();
    pol_addr_vld = '0;
    glb_ofm = rand_word(); glb_ofm_vld = 1'b1;
    cyc();
    glb_ofm_vld = 1'b0;
    #1;
    chk("stray_err", w_t'(mic_err), w_t'(1'b1));
    chk("stray_no_vld", w_t'(pol_ofm_vld), w_t'(6'b0));
    cyc();

    // Head tag 2 blocked while only port 0 is ready: output FIFO fills.
    do_reset();
    glb_addr_rdy = 1'b1;
    pol_ofm_rdy  = 6'b000001;
    for (int k = 0; k < 14; k++) begin
      pol_addr_vld = (k < 6) ? 6'b000100 : 6'b000000;
      pol_addr[2*AWD +: AWD] = AWD'(100 + k);
      cyc();
      glb_update(100);
    end
    #1;
    chk("fill_ofm_vld", w_t'(pol_ofm_vld), w_t'(6'b000100));
    chk("fill_ofm_rdy", w_t'(glb_ofm_rdy), w_t'(1'b0));

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      pol_addr_vld = NP'($urandom);
      for (int i = 0; i < NP; i++) pol_addr[i*AWD +: AWD] = AWD'($urandom);
      glb_addr_rdy = ($urandom_range(0, 99) < 70);
      pol_ofm_rdy  = NP'($urandom);
      cyc();
      glb_update(60);
    end

    // Drain everything, bounded.
    pol_addr_vld = '0; glb_addr_rdy = 1'b1; pol_ofm_rdy = '1;
    drained = 1'b0;
    for (int k = 0; k < 300 && !drained; k++) begin
      cyc();
      glb_update(100);
      drained = (m_cmd.size() == 0) && (m_infl == 0) && (m_out.size() == 0) && !glb_ofm_vld;
    end
    if (!drained) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: traffic still pending, required none");
    end

    // Stray word sets the sticky error ahead of the reset test.
    glb_ofm = rand_word(); glb_ofm_vld = 1'b1;
    cyc();
    glb_ofm_vld = 1'b0;
    cyc();

    // Back-to-back burst: address and data handshakes in the same cycle.
    pol_addr_vld = '1;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NP; i++) pol_addr[i*AWD +: AWD] = AWD'($urandom);
      cyc();
      glb_update(100);
    end

    // Asynchronous reset in the middle of the burst.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_glb_vld", w_t'(glb_addr_vld), w_t'(1'b0));
    chk("arst_ofm_vld", w_t'(pol_ofm_vld), w_t'(6'b0));
    chk("arst_ofm_rdy", w_t'(glb_ofm_rdy), w_t'(1'b1));
    chk("arst_err", w_t'(mic_err), w_t'(1'b0));
    chk("arst_rr_ptr", w_t'(pol_addr_rdy), w_t'(6'b000001));
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
